// File: rtl/hpu_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hpu_irq_ctrl_pkg
// Shared definitions for the HPU regif error/interrupt controller.
//   - IRQ_CFG_DATA_W : width of the regif config write data bus
//   - irq_sel_e      : cfg_wr_sel encoding (mask write, W1C clear, holdoff write)
//   - irq_state_e    : per-line coalescing FSM states
//   - irq_line_w()   : width of the line-select field for a given line count
// -----------------------------------------------------------------------------
package hpu_irq_ctrl_pkg;

  localparam int unsigned IRQ_CFG_DATA_W = 32;

  typedef enum logic [1:0] {
    IRQ_SEL_MASK    = 2'd0,
    IRQ_SEL_W1C     = 2'd1,
    IRQ_SEL_HOLDOFF = 2'd2,
    IRQ_SEL_RSVD    = 2'd3
  } irq_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    ASSERT = 2'd2
  } irq_state_e;

  // A single line still needs a one-bit select so the port never collapses to zero width.
  function automatic int unsigned irq_line_w(input int unsigned line_nb);
    return (line_nb > 1) ? $clog2(line_nb) : 1;
  endfunction

endpackage

// File: rtl/hpu_irq_line.sv
// -----------------------------------------------------------------------------
// hpu_irq_line
// One interrupt line: mask register, holdoff register, holdoff timer and the
// IDLE/HOLD/ASSERT coalescing FSM.
//
// Ports:
//   clk, arst_n    : clock and asynchronous active-low reset
//   err_sticky     : registered sticky error status shared by all lines
//   mask_wr        : load mask from mask_wdata on the next edge
//   mask_wdata     : new mask value
//   holdoff_wr     : load holdoff from holdoff_wdata on the next edge
//   holdoff_wdata  : new holdoff value in cycles (0 = assert without delay)
//   mask           : mask readback
//   interrupt      : level interrupt, high only while the FSM is in ASSERT
// -----------------------------------------------------------------------------
module hpu_irq_line
  import hpu_irq_ctrl_pkg::*;
#(
  parameter int unsigned ERROR_NB = 13,
  parameter int unsigned HOLD_W   = 12
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [ERROR_NB-1:0] err_sticky,
  input  logic                mask_wr,
  input  logic [ERROR_NB-1:0] mask_wdata,
  input  logic                holdoff_wr,
  input  logic [HOLD_W-1:0]   holdoff_wdata,
  output logic [ERROR_NB-1:0] mask,
  output logic                interrupt
);

  logic [ERROR_NB-1:0] mask_q;
  logic [HOLD_W-1:0]   holdoff_q;
  logic [HOLD_W-1:0]   timer_q, timer_d;
  irq_state_e          state_q, state_d;
  logic                pend;

  // Pending is built from registered sticky/mask so the FSM sees a stable level.
  assign pend = |(err_sticky & mask_q);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mask_q    <= '0;
      holdoff_q <= '0;
    end else begin
      if (mask_wr)    mask_q    <= mask_wdata;
      if (holdoff_wr) holdoff_q <= holdoff_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (pend) begin
          if (holdoff_q != '0) begin
            // Timer is a private copy: later holdoff writes do not disturb it.
            state_d = HOLD;
            timer_d = holdoff_q;
          end else begin
            state_d = ASSERT;
          end
        end
      end
      HOLD: begin
        // Losing pend wins over timer expiry, so a cleared source never fires.
        if (!pend) begin
          state_d = IDLE;
        end else if (timer_q == HOLD_W'(1)) begin
          state_d = ASSERT;
        end else begin
          timer_d = timer_q - HOLD_W'(1);
        end
      end
      ASSERT: begin
        if (!pend) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign mask      = mask_q;
  assign interrupt = (state_q == ASSERT);

endmodule

// File: rtl/hpu_irq_ctrl.sv
// -----------------------------------------------------------------------------
// hpu_irq_ctrl
// Error/interrupt controller for the HPU regif level. Latches single-cycle
// error pulses into a sticky W1C status, optionally counts them per source,
// and drives IRQ_NB level interrupts, each with its own mask and holdoff.
//
// Build option:
//   HPU_IRQ_ERR_CNT_EN : when defined, per-error saturating counters are built;
//                        when undefined, err_cnt is tied to zero.
//
// Ports:
//   prc_clk, prc_arst_n : clock and asynchronous active-low reset
//   error               : one-cycle error event pulses, one bit per source
//   cfg_wr_vld          : config write strobe (single cycle)
//   cfg_wr_sel          : 0 mask, 1 W1C status clear, 2 holdoff, 3 ignored
//   cfg_wr_line         : target line for mask/holdoff; out-of-range is ignored
//   cfg_wdata           : write data (error bits or holdoff in low bits)
//   err_sticky          : sticky error status
//   err_cnt             : per-error counters, source i at [i*CNT_W +: CNT_W]
//   irq_mask            : mask readback, line k at [k*ERROR_NB +: ERROR_NB]
//   interrupt           : level interrupts
// -----------------------------------------------------------------------------
module hpu_irq_ctrl
  import hpu_irq_ctrl_pkg::*;
#(
  parameter  int unsigned ERROR_NB = 13,
  parameter  int unsigned IRQ_NB   = 2,
  parameter  int unsigned CNT_W    = 16,
  parameter  int unsigned HOLD_W   = 12,
  localparam int unsigned LINE_W   = irq_line_w(IRQ_NB)
) (
  input  logic                         prc_clk,
  input  logic                         prc_arst_n,
  input  logic [ERROR_NB-1:0]          error,
  input  logic                         cfg_wr_vld,
  input  logic [1:0]                   cfg_wr_sel,
  input  logic [LINE_W-1:0]            cfg_wr_line,
  input  logic [IRQ_CFG_DATA_W-1:0]    cfg_wdata,
  output logic [ERROR_NB-1:0]          err_sticky,
  output logic [ERROR_NB*CNT_W-1:0]    err_cnt,
  output logic [IRQ_NB*ERROR_NB-1:0]   irq_mask,
  output logic [IRQ_NB-1:0]            interrupt
);

  irq_sel_e            sel;
  logic                mask_wr_any;
  logic                holdoff_wr_any;
  logic [ERROR_NB-1:0] w1c;
  logic [ERROR_NB-1:0] err_sticky_q, err_sticky_d;
  logic                unused_wdata;

  assign sel            = irq_sel_e'(cfg_wr_sel);
  assign mask_wr_any    = cfg_wr_vld && (sel == IRQ_SEL_MASK);
  assign holdoff_wr_any = cfg_wr_vld && (sel == IRQ_SEL_HOLDOFF);
  assign w1c            = (cfg_wr_vld && (sel == IRQ_SEL_W1C)) ? cfg_wdata[ERROR_NB-1:0] : '0;

  // Bits above ERROR_NB / HOLD_W are don't-care.
  assign unused_wdata = ^cfg_wdata;

  // ---------------------------------------------------------------------------
  // Sticky status: a new event in the same cycle as a clear keeps the bit set.
  // ---------------------------------------------------------------------------
  assign err_sticky_d = (err_sticky_q & ~w1c) | error;

  always_ff @(posedge prc_clk or negedge prc_arst_n) begin
    if (!prc_arst_n) begin
      err_sticky_q <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;

  // ---------------------------------------------------------------------------
  // Per-error occurrence counters
  // ---------------------------------------------------------------------------
`ifdef HPU_IRQ_ERR_CNT_EN
  for (genvar i = 0; i < ERROR_NB; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (w1c[i]) begin
        // Clear and event together: the event that kept sticky set is counted.
        cnt_d = error[i] ? CNT_W'(1) : '0;
      end else if (error[i] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge prc_clk or negedge prc_arst_n) begin
      if (!prc_arst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign err_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign err_cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // Interrupt lines. A line index beyond IRQ_NB matches no instance and is dropped.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < IRQ_NB; k++) begin : g_line
    logic line_hit;

    assign line_hit = (cfg_wr_line == LINE_W'(k));

    hpu_irq_line #(
      .ERROR_NB (ERROR_NB),
      .HOLD_W   (HOLD_W)
    ) u_line (
      .clk           (prc_clk),
      .arst_n        (prc_arst_n),
      .err_sticky    (err_sticky_q),
      .mask_wr       (mask_wr_any && line_hit),
      .mask_wdata    (cfg_wdata[ERROR_NB-1:0]),
      .holdoff_wr    (holdoff_wr_any && line_hit),
      .holdoff_wdata (cfg_wdata[HOLD_W-1:0]),
      .mask          (irq_mask[k*ERROR_NB +: ERROR_NB]),
      .interrupt     (interrupt[k])
    );
  end

endmodule

// File: tb/tb_hpu_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hpu_irq_ctrl
// Self-checking bench for hpu_irq_ctrl. The reference model tracks sticky
// bits, counts, masks and holdoffs as plain arrays and predicts each interrupt
// from the length of the current uninterrupted pending run: a line is high
// once pend has been seen on at least holdoff+1 consecutive edges, with the
// holdoff taken at the first edge of the run.
// -----------------------------------------------------------------------------
module tb_hpu_irq_ctrl;
  import hpu_irq_ctrl_pkg::*;

  localparam int unsigned ERROR_NB = 13;
  localparam int unsigned IRQ_NB   = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned HOLD_W   = 12;
  localparam int unsigned LINE_W   = 2;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;
`ifdef HPU_IRQ_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                        prc_clk = 1'b0;
  logic                        prc_arst_n = 1'b0;
  logic [ERROR_NB-1:0]         error = '0;
  logic                        cfg_wr_vld = 1'b0;
  logic [1:0]                  cfg_wr_sel = '0;
  logic [LINE_W-1:0]           cfg_wr_line = '0;
  logic [IRQ_CFG_DATA_W-1:0]   cfg_wdata = '0;
  logic [ERROR_NB-1:0]         err_sticky;
  logic [ERROR_NB*CNT_W-1:0]   err_cnt;
  logic [IRQ_NB*ERROR_NB-1:0]  irq_mask;
  logic [IRQ_NB-1:0]           interrupt;

  hpu_irq_ctrl #(
    .ERROR_NB (ERROR_NB),
    .IRQ_NB   (IRQ_NB),
    .CNT_W    (CNT_W),
    .HOLD_W   (HOLD_W)
  ) dut (
    .prc_clk     (prc_clk),
    .prc_arst_n  (prc_arst_n),
    .error       (error),
    .cfg_wr_vld  (cfg_wr_vld),
    .cfg_wr_sel  (cfg_wr_sel),
    .cfg_wr_line (cfg_wr_line),
    .cfg_wdata   (cfg_wdata),
    .err_sticky  (err_sticky),
    .err_cnt     (err_cnt),
    .irq_mask    (irq_mask),
    .interrupt   (interrupt)
  );

  always #5 prc_clk = ~prc_clk;

  // Reference model state
  logic [ERROR_NB-1:0] m_sticky;
  int                  m_cnt  [ERROR_NB];
  logic [ERROR_NB-1:0] m_mask [IRQ_NB];
  int                  m_hold [IRQ_NB];
  int                  m_run  [IRQ_NB];
  int                  m_cap  [IRQ_NB];

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sticky = '0;
    for (int i = 0; i < ERROR_NB; i++) m_cnt[i] = 0;
    for (int k = 0; k < IRQ_NB; k++) begin
      m_mask[k] = '0;
      m_hold[k] = 0;
      m_run[k]  = 0;
      m_cap[k]  = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [ERROR_NB-1:0] clr;
    for (int k = 0; k < IRQ_NB; k++) begin
      if ((m_sticky & m_mask[k]) != '0) begin
        if (m_run[k] == 0) m_cap[k] = m_hold[k];
        m_run[k]++;
      end else begin
        m_run[k] = 0;
      end
    end
    clr = (cfg_wr_vld && cfg_wr_sel == 2'd1) ? cfg_wdata[ERROR_NB-1:0] : '0;
    for (int i = 0; i < ERROR_NB; i++) begin
      if (clr[i])        m_cnt[i] = error[i] ? 1 : 0;
      else if (error[i]) m_cnt[i] = (m_cnt[i] < CNT_MAX) ? m_cnt[i] + 1 : CNT_MAX;
    end
    m_sticky = (m_sticky & ~clr) | error;
    if (cfg_wr_vld && int'(cfg_wr_line) < IRQ_NB) begin
      if (cfg_wr_sel == 2'd0) m_mask[cfg_wr_line] = cfg_wdata[ERROR_NB-1:0];
      if (cfg_wr_sel == 2'd2) m_hold[cfg_wr_line] = int'(cfg_wdata[HOLD_W-1:0]);
    end
  endtask

  function automatic int exp_cnt(input int i);
    return CNT_EN ? m_cnt[i] : 0;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < IRQ_NB; k++) begin
      check_eq($sformatf("irq%0d", k), 64'(interrupt[k]), 64'(m_run[k] > m_cap[k]));
      check_eq($sformatf("mask%0d", k), 64'(irq_mask[k*ERROR_NB +: ERROR_NB]), 64'(m_mask[k]));
    end
    check_eq("sticky", 64'(err_sticky), 64'(m_sticky));
    for (int i = 0; i < ERROR_NB; i++)
      check_eq($sformatf("cnt%0d", i), 64'(err_cnt[i*CNT_W +: CNT_W]), 64'(exp_cnt(i)));
  endtask

  // Inputs are changed only between a negedge and the following posedge.
  task automatic tick(input bit chk = 1'b1);
    @(posedge prc_clk);
    model_edge();
    @(negedge prc_clk);
    if (chk) compare_all();
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int line, input logic [31:0] data);
    cfg_wr_vld  = 1'b1;
    cfg_wr_sel  = sel;
    cfg_wr_line = LINE_W'(line);
    cfg_wdata   = data;
    tick();
    cfg_wr_vld  = 1'b0;
    cfg_wdata   = '0;
  endtask

  task automatic pulse(input logic [ERROR_NB-1:0] ev);
    error = ev;
    tick();
    error = '0;
  endtask

  // Called just after a negedge; reset lands mid-cycle, away from any edge.
  task automatic async_reset(input string tag);
    #2 prc_arst_n = 1'b0;
    #1;
    check_eq({tag, "_irq"}, 64'(interrupt), 64'd0);
    check_eq({tag, "_sticky"}, 64'(err_sticky), 64'd0);
    check_eq({tag, "_mask"}, 64'(irq_mask), 64'd0);
    check_eq({tag, "_cnt"}, 64'(|err_cnt), 64'd0);
    model_reset();
    error      = '0;
    cfg_wr_vld = 1'b0;
    @(negedge prc_clk);
    @(negedge prc_clk);
    prc_arst_n = 1'b1;
  endtask

  logic [IRQ_NB*ERROR_NB-1:0] mask_snap;

  initial begin
    model_reset();
    repeat (2) @(negedge prc_clk);
    compare_all();
    prc_arst_n = 1'b1;

    // Unmasked event: status and count only
    pulse(13'h008);
    check_eq("sticky_e3", 64'(err_sticky), 64'h008);
    check_eq("cnt3_e3", 64'(err_cnt[3*CNT_W +: CNT_W]), CNT_EN ? 64'd1 : 64'd0);
    check_eq("irq_nomask", 64'(interrupt), 64'd0);
    tick();

    // Line 0, holdoff 0: interrupt two edges after the pulse
    cfg_write(2'd1, 0, 32'h008);
    cfg_write(2'd0, 0, 32'h008);
    pulse(13'h008);
    check_eq("lat0_n1", 64'(interrupt[0]), 64'd0);
    tick();
    check_eq("lat0_n2", 64'(interrupt[0]), 64'd1);
    cfg_write(2'd1, 0, 32'h008);
    check_eq("w1c_edge1", 64'(interrupt[0]), 64'd1);
    tick();
    check_eq("w1c_edge2", 64'(interrupt[0]), 64'd0);

    // Line 1, holdoff 5: interrupt at N+7
    cfg_write(2'd2, 1, 32'd5);
    cfg_write(2'd0, 1, 32'h1000);
    pulse(13'h1000);
    check_eq("hold_e1", 64'(interrupt[1]), 64'd0);
    for (int e = 2; e <= 8; e++) begin
      tick();
      check_eq($sformatf("hold_e%0d", e), 64'(interrupt[1]), 64'(e >= 7));
    end
    cfg_write(2'd1, 0, 32'h1000);
    tick();
    check_eq("hold_clr", 64'(interrupt[1]), 64'd0);

    // Same, but clear before expiry: never asserts
    pulse(13'h1000);
    repeat (3) tick();
    cfg_write(2'd1, 0, 32'h1000);
    for (int e = 0; e < 6; e++) begin
      tick();
      check_eq("hold_abort", 64'(interrupt[1]), 64'd0);
    end

    // Counter saturation, then clear coinciding with a new event
    error = 13'h001;
    repeat ((1 << CNT_W) + 3) tick(1'b0);
    error = '0;
    tick();
    check_eq("cnt0_sat", 64'(err_cnt[0 +: CNT_W]), CNT_EN ? 64'hFFFF : 64'd0);
    error       = 13'h001;
    cfg_wr_vld  = 1'b1;
    cfg_wr_sel  = 2'd1;
    cfg_wr_line = '0;
    cfg_wdata   = 32'h1;
    tick();
    error      = '0;
    cfg_wr_vld = 1'b0;
    check_eq("w1c_set_sticky", 64'(err_sticky[0]), 64'd1);
    check_eq("w1c_set_cnt", 64'(err_cnt[0 +: CNT_W]), CNT_EN ? 64'd1 : 64'd0);

    // Ignored writes: out-of-range line and reserved select
    mask_snap = irq_mask;
    cfg_write(2'd0, 3, 32'hFFFF_FFFF);
    cfg_write(2'd3, 0, 32'hFFFF_FFFF);
    cfg_write(2'd3, 1, 32'hFFFF_FFFF);
    check_eq("ign_mask", 64'(irq_mask), 64'(mask_snap));
    check_eq("ign_mask_abs", 64'(irq_mask), 64'({13'h0000, 13'h1000, 13'h0008}));

    // Asynchronous reset in HOLD, then in ASSERT
    cfg_write(2'd1, 0, 32'h1FFF);
    cfg_write(2'd2, 0, 32'd20);
    cfg_write(2'd0, 0, 32'h001);
    pulse(13'h001);
    repeat (3) tick();
    check_eq("pre_rst_hold", 64'(interrupt[0]), 64'd0);
    async_reset("rst_hold");
    cfg_write(2'd0, 0, 32'h001);
    pulse(13'h001);
    tick();
    check_eq("pre_rst_assert", 64'(interrupt[0]), 64'd1);
    async_reset("rst_assert");
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      error = ERROR_NB'($urandom & $urandom & $urandom);
      cfg_wr_vld = ($urandom_range(0, 3) == 0);
      cfg_wr_sel = 2'($urandom_range(0, 3));
      cfg_wr_line = LINE_W'($urandom_range(0, 3));
      cfg_wdata = $urandom;
      if (cfg_wr_sel == 2'd2) cfg_wdata[HOLD_W-1:0] = HOLD_W'($urandom_range(0, 6));
      tick();
    end
    error      = '0;
    cfg_wr_vld = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
